// File: rtl/cprv_pkg.sv
// Shared types for the cprv memory arbiter: FSM state encoding and requester identity.
package cprv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        SRC_IMEM,
        SRC_DMEM
    } arb_src_t;

endpackage

// File: rtl/cprv_rr_arb2.sv
// Two-input round-robin grant logic with its last_grant register; on contention
// the source that was not served last wins.
module cprv_rr_arb2
    import cprv_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_valid,
    input  logic     d_valid,
    input  logic     update_en,
    input  arb_src_t update_src,
    output logic     grant_valid,
    output arb_src_t grant_src
);

    arb_src_t last_grant;

    // Reset to IMEM so the very first contention is resolved in favour of dmem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_IMEM;
        end else if (update_en) begin
            last_grant <= update_src;
        end
    end

    always_comb begin
        grant_valid = i_valid | d_valid;
        grant_src   = SRC_IMEM;
        if (i_valid && d_valid) begin
            grant_src = (last_grant == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
        end else if (d_valid) begin
            grant_src = SRC_DMEM;
        end
    end

endmodule

// File: rtl/cprv_mem_arbiter.sv
// Shares a single-ported memory between instruction fetch and data access,
// keeping exactly one transaction in flight and steering each response home.
module cprv_mem_arbiter
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid_i,
    output logic                  i_req_ready_o,
    input  logic [DATA_WIDTH-1:0] i_req_addr_i,
    output logic                  i_rsp_valid_o,
    input  logic                  i_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] i_rsp_data_o,
    input  logic                  d_req_valid_i,
    output logic                  d_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] d_req_addr_i,
    input  logic [DATA_WIDTH-1:0] d_req_wdata_i,
    input  logic                  d_req_w_en_i,
    output logic                  d_rsp_valid_o,
    input  logic                  d_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] d_rsp_data_o,
    output logic                  m_req_valid_o,
    input  logic                  m_req_ready_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    output logic                  m_w_en_o,
    input  logic                  m_rsp_valid_i,
    output logic                  m_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0] m_rdata_i
);

    arb_state_t            state_q, state_d;
    arb_src_t              src_q;
    arb_src_t              grant_src;
    logic                  grant_valid;
    logic                  req_xfer;
    logic                  rsp_done;
    logic [ADDR_WIDTH-1:0] addr_q, gnt_addr;
    logic [DATA_WIDTH-1:0] wdata_q, gnt_wdata;
    logic                  w_en_q, gnt_w_en;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Fetch byte addresses select a word; the byte offset and high bits are dropped.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{i_req_addr_i[DATA_WIDTH-1:ADDR_WIDTH+3], i_req_addr_i[2:0]};

    cprv_rr_arb2 u_rr_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_req_valid_i),
        .d_valid     (d_req_valid_i),
        .update_en   (rsp_done),
        .update_src  (src_q),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    always_comb begin
        state_d       = state_q;
        req_xfer      = 1'b0;
        rsp_done      = 1'b0;
        i_req_ready_o = 1'b0;
        d_req_ready_o = 1'b0;
        gnt_addr      = i_req_addr_i[ADDR_WIDTH+2:3];
        gnt_wdata     = '0;
        gnt_w_en      = 1'b0;
        if (grant_src == SRC_DMEM) begin
            gnt_addr  = d_req_addr_i;
            gnt_wdata = d_req_wdata_i;
            gnt_w_en  = d_req_w_en_i;
        end
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    i_req_ready_o = (grant_src == SRC_IMEM);
                    d_req_ready_o = (grant_src == SRC_DMEM);
                    req_xfer      = 1'b1;
                    state_d       = REQ;
                end
            end
            REQ:  if (m_req_ready_i) state_d = WAIT;
            WAIT: if (m_rsp_valid_i) state_d = RESP;
            RESP: begin
                if ((src_q == SRC_IMEM) ? i_rsp_ready_i : d_rsp_ready_i) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One payload register set serves both sources; stores answer with zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= SRC_IMEM;
            addr_q  <= '0;
            wdata_q <= '0;
            w_en_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (req_xfer) begin
                src_q   <= grant_src;
                addr_q  <= gnt_addr;
                wdata_q <= gnt_wdata;
                w_en_q  <= gnt_w_en;
            end
            if (state_q == WAIT && m_rsp_valid_i) begin
                rdata_q <= w_en_q ? '0 : m_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_valid_o <= 1'b0;
            m_w_en_o      <= 1'b0;
            m_rsp_ready_o <= 1'b0;
            i_rsp_valid_o <= 1'b0;
            d_rsp_valid_o <= 1'b0;
        end else begin
            m_req_valid_o <= (state_d == REQ);
            m_w_en_o      <= (state_d == REQ) && (req_xfer ? gnt_w_en : w_en_q);
            m_rsp_ready_o <= (state_d == WAIT);
            i_rsp_valid_o <= (state_d == RESP) && (src_q == SRC_IMEM);
            d_rsp_valid_o <= (state_d == RESP) && (src_q == SRC_DMEM);
        end
    end

    assign m_addr_o     = addr_q;
    assign m_wdata_o    = wdata_q;
    assign i_rsp_data_o = rdata_q;
    assign d_rsp_data_o = rdata_q;

endmodule
